tick_scheduler: RTL and testbench

Shares one prescaler among NCH requesters. Each requester gets a programmable-period enable pulse and a square-wave clock-enable output, so multiple slow-rate consumers (display scan, debounce, blink) stop carrying private 32-bit divider counters. The block sits next to the board clock and feeds slow-rate consumers through enables on `clkin`, never as derived clocks.

---
 rtl/tick_sched_pkg.sv | 18 +
 rtl/tick_scheduler_if.sv | 31 +++
 rtl/tick_sched_chan.sv | 65 ++++++
 rtl/tick_scheduler.sv | 102 ++++++++++
 tb/tb_tick_scheduler.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared state enum, default constants and width helper for tick_scheduler
package tick_sched_pkg;

  localparam int unsigned DEF_PRESCALE = 50000;
  localparam int unsigned DEF_NCH      = 4;
  localparam int unsigned DEF_PER_W    = 16;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } cfg_state_e;

  // Channel-select width never collapses to zero, even for a single channel.
  function automatic int unsigned ch_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - channel configuration request/ready bundle
interface tick_scheduler_if #(
  parameter int unsigned NCH   = tick_sched_pkg::DEF_NCH,
  parameter int unsigned PER_W = tick_sched_pkg::DEF_PER_W
);

  localparam int unsigned CH_W = tick_sched_pkg::ch_width(NCH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [PER_W-1:0] cfg_period;
  logic             cfg_en;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_period,
    output cfg_en,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_period,
    input  cfg_en,
    output cfg_ready
  );

endinterface

// File: rtl/tick_sched_chan.sv
// rtl/tick_sched_chan.sv - one channel: enable, period, base-tick counter, tick pulse and square wave
module tick_sched_chan #(
  parameter int unsigned PER_W = 16
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             base_tick,
  input  logic             apply,
  input  logic             new_en,
  input  logic [PER_W-1:0] new_period,
  output logic             tick_o,
  output logic             clkout
);

  logic             en_q, en_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [PER_W-1:0] c_q, c_d;
  logic             clkout_q, clkout_d;
  logic             tick_q, tick_d;
  logic             en_eff;

  always_comb begin
    en_eff   = new_en && (new_period != '0);
    en_d     = en_q;
    per_d    = per_q;
    c_d      = c_q;
    clkout_d = clkout_q;
    tick_d   = 1'b0;
    // A new configuration overrides any count that lands on the same edge.
    if (apply) begin
      en_d     = en_eff;
      per_d    = new_period;
      c_d      = '0;
      clkout_d = en_eff & clkout_q;
    end else if (base_tick && en_q) begin
      if (c_q == per_q - 1'b1) begin
        c_d      = '0;
        tick_d   = 1'b1;
        clkout_d = ~clkout_q;
      end else begin
        c_d = c_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      en_q     <= 1'b0;
      per_q    <= '0;
      c_q      <= '0;
      clkout_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      en_q     <= en_d;
      per_q    <= per_d;
      c_q      <= c_d;
      clkout_q <= clkout_d;
      tick_q   <= tick_d;
    end
  end

  assign tick_o = tick_q;
  assign clkout = clkout_q;

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - shared prescaler, single-slot config FSM and NCH tick channels
// Optional macro TICK_SCHED_IMMEDIATE_EN: apply pending config one cycle after acceptance.
module tick_scheduler
  import tick_sched_pkg::*;
#(
  parameter int unsigned PRESCALE = DEF_PRESCALE,
  parameter int unsigned NCH      = DEF_NCH,
  parameter int unsigned PER_W    = DEF_PER_W
) (
  input  logic               clkin,
  input  logic               rst_n,
  tick_scheduler_if.slave    cfg,
  output logic               base_tick,
  output logic [NCH-1:0]     tick_o,
  output logic [NCH-1:0]     clkout
);

  localparam int unsigned      PCNT_W    = $clog2(PRESCALE);
  localparam int unsigned      CH_W      = ch_width(NCH);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] pcnt_q, pcnt_d;

  cfg_state_e        state_q, state_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
  logic [PER_W-1:0]  pend_period_q, pend_period_d;
  logic              pend_en_q, pend_en_d;
  logic              apply_now;

  assign base_tick = (pcnt_q == PCNT_LAST);

  always_comb begin
    pcnt_d = base_tick ? '0 : pcnt_q + 1'b1;
  end

`ifdef TICK_SCHED_IMMEDIATE_EN
  assign apply_now = (state_q == ST_PENDING);
`else
  assign apply_now = (state_q == ST_PENDING) && base_tick;
`endif

  always_comb begin
    state_d       = state_q;
    pend_ch_d     = pend_ch_q;
    pend_period_d = pend_period_q;
    pend_en_d     = pend_en_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_valid) begin
          pend_ch_d     = cfg.cfg_ch;
          pend_period_d = cfg.cfg_period;
          pend_en_d     = cfg.cfg_en;
          state_d       = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (apply_now) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    cfg_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      pcnt_q        <= '0;
      state_q       <= ST_IDLE;
      cfg_ready_q   <= 1'b1;
      pend_ch_q     <= '0;
      pend_period_q <= '0;
      pend_en_q     <= 1'b0;
    end else begin
      pcnt_q        <= pcnt_d;
      state_q       <= state_d;
      cfg_ready_q   <= cfg_ready_d;
      pend_ch_q     <= pend_ch_d;
      pend_period_q <= pend_period_d;
      pend_en_q     <= pend_en_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    tick_sched_chan #(
      .PER_W(PER_W)
    ) u_chan (
      .clkin      (clkin),
      .rst_n      (rst_n),
      .base_tick  (base_tick),
      .apply      (apply_now && (pend_ch_q == CH_W'(i))),
      .new_en     (pend_en_q),
      .new_period (pend_period_q),
      .tick_o     (tick_o[i]),
      .clkout     (clkout[i])
    );
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed checks of tick_scheduler with PRESCALE=4, NCH=4, PER_W=8
module tb_tick_scheduler;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic       base_tick;
  logic [3:0] tick_o;
  logic [3:0] clkout;
  int         n_total = 0;
  int         n_bad = 0;
  int         cyc = 0;

  tick_scheduler_if #(.NCH(4), .PER_W(8)) cfg_if ();

  tick_scheduler #(
    .PRESCALE(4),
    .NCH     (4),
    .PER_W   (8)
  ) dut (
    .clkin    (clkin),
    .rst_n    (rst_n),
    .cfg      (cfg_if),
    .base_tick(base_tick),
    .tick_o   (tick_o),
    .clkout   (clkout)
  );

  always #5 clkin = ~clkin;

  task automatic step();
    @(posedge clkin);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] ch, input logic [7:0] per, input logic en);
    cfg_if.cfg_valid  = v;
    cfg_if.cfg_ch     = ch;
    cfg_if.cfg_period = per;
    cfg_if.cfg_en     = en;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    step();
    rst_n = 1'b1;
    cyc = 0;
  endtask

  initial begin
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    rst_n = 1'b0;
    repeat (2) begin
      step();
      chk("rst_ready", cfg_if.cfg_ready, 1);
      chk("rst_tick", tick_o, 0);
      chk("rst_clkout", clkout, 0);
      chk("rst_base", base_tick, 0);
    end
    rst_n = 1'b1;
    cyc = 0;

`ifdef TICK_SCHED_IMMEDIATE_EN
    drive(1'b1, 2'd0, 8'd2, 1'b1);
    chk("im_rdy0", cfg_if.cfg_ready, 1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("im_rdy1", cfg_if.cfg_ready, 0);
    step();
    chk("im_rdy2", cfg_if.cfg_ready, 1);
    while (cyc < 4) step();
    chk("im_tick4", tick_o, 4'b0000);
    while (cyc < 8) step();
    chk("im_tick8", tick_o, 4'b0001);
    chk("im_clk8", clkout, 4'b0001);
    drive(1'b1, 2'd1, 8'd1, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("im_rdy9", cfg_if.cfg_ready, 0);
    step();
    chk("im_rdy10", cfg_if.cfg_ready, 1);
    while (cyc < 14) step();
    drive(1'b1, 2'd0, 8'd3, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("im_rdy15", cfg_if.cfg_ready, 0);
    step();
    chk("im_tick16", tick_o, 4'b0010);
    chk("im_clk16", clkout, 4'b0001);
`else
    // Base tick cadence plus ch0 P=2 accepted in cycle 1.
    chk("A_rdy0", cfg_if.cfg_ready, 1);
    chk("A_base0", base_tick, 0);
    step();
    drive(1'b1, 2'd0, 8'd2, 1'b1);
    chk("A_rdy1", cfg_if.cfg_ready, 1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    while (cyc <= 28) begin
      chk("A_base", base_tick, (cyc % 4) == 3);
      chk("A_rdy", cfg_if.cfg_ready, cyc >= 4);
      chk("A_tick", tick_o, {3'b000, (cyc == 12) || (cyc == 20) || (cyc == 28)});
      chk("A_clk", clkout, {3'b000, ((cyc >= 12) && (cyc < 20)) || (cyc >= 28)});
      step();
    end

    // ch1 P=1, then ch2 P=2 held through PENDING.
    do_reset();
    drive(1'b1, 2'd1, 8'd1, 1'b1);
    chk("B_rdy0", cfg_if.cfg_ready, 1);
    step();
    drive(1'b1, 2'd2, 8'd2, 1'b1);
    chk("B_rdy1", cfg_if.cfg_ready, 0);
    step();
    chk("B_rdy2", cfg_if.cfg_ready, 0);
    step();
    chk("B_rdy3", cfg_if.cfg_ready, 0);
    chk("B_base3", base_tick, 1);
    step();
    chk("B_rdy4", cfg_if.cfg_ready, 1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("B_rdy5", cfg_if.cfg_ready, 0);
    while (cyc < 8) step();
    chk("B_tick8", tick_o, 4'b0010);
    chk("B_clk8", clkout, 4'b0010);
    chk("B_rdy8", cfg_if.cfg_ready, 1);
    step();
    chk("B_tick9", tick_o, 4'b0000);
    while (cyc < 12) step();
    chk("B_tick12", tick_o, 4'b0010);
    chk("B_clk12", clkout, 4'b0000);
    while (cyc < 16) step();
    chk("B_tick16", tick_o, 4'b0110);
    chk("B_clk16", clkout, 4'b0110);

    // Reapply ch0 P=3 on the edge where it would tick.
    do_reset();
    step();
    drive(1'b1, 2'd0, 8'd2, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    while (cyc < 12) step();
    chk("C_tick12", tick_o, 4'b0001);
    chk("C_clk12", clkout, 4'b0001);
    while (cyc < 16) step();
    drive(1'b1, 2'd0, 8'd3, 1'b1);
    chk("C_rdy16", cfg_if.cfg_ready, 1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("C_rdy17", cfg_if.cfg_ready, 0);
    while (cyc < 20) step();
    chk("C_tick20", tick_o, 4'b0000);
    chk("C_clk20", clkout, 4'b0001);
    chk("C_rdy20", cfg_if.cfg_ready, 1);
    while (cyc < 24) step();
    chk("C_tick24", tick_o, 4'b0000);
    while (cyc < 28) step();
    chk("C_tick28", tick_o, 4'b0000);
    chk("C_clk28", clkout, 4'b0001);
    while (cyc < 32) step();
    chk("C_tick32", tick_o, 4'b0001);
    chk("C_clk32", clkout, 4'b0000);

    // ch3 with period 0 stays off; then reset with a request pending.
    drive(1'b1, 2'd3, 8'd0, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    while (cyc < 44) begin
      chk("D_tick3", tick_o[3], 0);
      chk("D_clk3", clkout[3], 0);
      step();
    end
    chk("D_tick44", tick_o, 4'b0001);
    chk("D_clk44", clkout, 4'b0001);
    drive(1'b1, 2'd1, 8'd1, 1'b1);
    step();
    drive(1'b0, 2'd0, 8'd0, 1'b0);
    chk("D_rdy45", cfg_if.cfg_ready, 0);
    rst_n = 1'b0;
    step();
    chk("D_rst_tick", tick_o, 0);
    chk("D_rst_clk", clkout, 0);
    chk("D_rst_base", base_tick, 0);
    chk("D_rst_rdy", cfg_if.cfg_ready, 1);
    rst_n = 1'b1;
    cyc = 0;
    while (cyc < 20) begin
      chk("D_post_tick", tick_o, 0);
      chk("D_post_clk", clkout, 0);
      chk("D_post_rdy", cfg_if.cfg_ready, 1);
      step();
    end
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
